alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Execute-stage ALU directly downstream of the ALU control decoder; consumes its 5-bit alu_control code.
//  Performs RV32I ops in 1 cycle and RV32M MUL*/DIV*/REM* through an iterative engine, all via valid/ready.
//  Result and zero flag are registered and held until the writeback/branch logic takes them.
// PARAMETERS
//  XLEN  32  operand/result width; shift amount = op_b[$clog2(XLEN)-1:0]
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     reset, synchronous, active-low
//  flush        in   1     pipeline kill; drops in-flight op and held result
//  in_valid     in   1     operation offered
//  in_ready     out  1     operation can be accepted this cycle
//  alu_control  in   5     op code: 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR, 05 SLT, 06 SLTU, 07 SLL, 08 SRL, 09 SRA,
//                          0A MUL, 0B MULH, 0C MULHSU, 0D MULHU, 0E DIV, 0F DIVU, 10 REM, 11 REMU
//  op_a         in   XLEN  rs1 / first operand
//  op_b         in   XLEN  rs2 or immediate
//  out_valid    out  1     result register holds a valid result
//  out_ready    in   1     consumer takes result this cycle
//  result       out  XLEN  registered result
//  zero         out  1     registered (result == 0), for branch compare
//  busy         out  1     iterative engine active
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, out_valid=0, result=0, zero=0, busy=0, iteration counter=0; any in-flight op aborted.
//  - States: IDLE, ITER. in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  - Single-cycle ops (00-09, codes 12-1F treated as ADD): result/zero written on accept edge; out_valid=1 next cycle.
//  - Iterative ops: accept edge latches operands, IDLE->ITER, count=0, busy=1. One step per cycle, 32 steps;
//    on the 32nd step edge: result written, out_valid=1, ITER->IDLE, busy=0. Latency = 32 cycles from accept.
//  - Signed ops run on magnitudes, then sign-fixed: quotient negated if signs differ; remainder takes dividend sign.
//    MULHSU: op_a signed, op_b unsigned. MUL returns low XLEN of product; MULH* return high XLEN.
//  - Division specials resolved at accept, 1-cycle latency, no ITER: divisor 0 -> DIV/DIVU all-ones, REM/REMU = op_a;
//    DIV of 0x80000000 by -1 -> 0x80000000, REM -> 0.
//  - SLT/SLTU write 0/1; SRA sign-fills; shift amount uses op_b[4:0] only (XLEN=32).
//  - Output hold: out_valid && !out_ready keeps result/zero stable; new accept blocked.
//    out_valid && out_ready with same-cycle accept: old result consumed, new one replaces it (back-to-back, no bubble).
//  - flush=1 at edge: state IDLE, out_valid=0, busy=0; flush wins over simultaneous accept (op dropped).
//  - Operand/op changes while busy are ignored (latched at accept).
// CONFIGURATION
//  ALU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU complete in 1 cycle via 64-bit combinational multiply, never enter ITER.
//  Not defined: multiplies use 32-step shift-add in the iterative engine, 32-cycle latency like divides.
//  Divides are iterative in both builds.
// STRUCTURE
//  - alu_pkg: localparams for all 5-bit op codes (shared with the control decoder), state enum, is_muldiv/is_div helpers.
//  - Sub-module alu_muldiv_iter: start/done iterative engine (restoring divide, shift-add multiply), 6-bit counter,
//    64-bit accumulator; top block owns handshake, special cases, sign fixup and output register.
// TESTING
//  1. ADD 7+5, SUB 5-5, SRA 0xF0000000>>4 -> 12 (zero=0), 0 (zero=1), 0xFF000000; out_valid exactly 1 cycle after accept.
//  2. DIV -7/2, REM -7/2, DIVU 100/7 -> 0xFFFFFFFD, 0xFFFFFFFF, 14; out_valid after 32 cycles, in_ready=0 while busy.
//  3. DIV 5/0, REMU 5/0, DIV 0x80000000/-1 -> 0xFFFFFFFF, 5, 0x80000000; each 1-cycle latency.
//  4. MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU -1*2 -> 0xFFFFFFFF; check 1- vs 32-cycle per ALU_FAST_MUL_EN.
//  5. out_ready=0 for 10 cycles after result -> result stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept.
//  6. flush at iteration 10 of DIVU, and rst_n=0 mid-ITER -> out_valid=0, busy=0, in_ready=1 next cycle; next ADD correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the execute-stage ALU.
// Used by alu_multicycle and alu_muldiv_iter; optional build macro ALU_FAST_MUL_EN lives in the top.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_SLT    = 5'h05;
    localparam logic [4:0] OP_SLTU   = 5'h06;
    localparam logic [4:0] OP_SLL    = 5'h07;
    localparam logic [4:0] OP_SRL    = 5'h08;
    localparam logic [4:0] OP_SRA    = 5'h09;
    localparam logic [4:0] OP_MUL    = 5'h0A;
    localparam logic [4:0] OP_MULH   = 5'h0B;
    localparam logic [4:0] OP_MULHSU = 5'h0C;
    localparam logic [4:0] OP_MULHU  = 5'h0D;
    localparam logic [4:0] OP_DIV    = 5'h0E;
    localparam logic [4:0] OP_DIVU   = 5'h0F;
    localparam logic [4:0] OP_REM    = 5'h10;
    localparam logic [4:0] OP_REMU   = 5'h11;

    typedef enum logic {S_IDLE, S_ITER} state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: restoring divide or shift-add multiply, one bit per step.
// Accumulator is {hi, lo}: product, or {remainder, quotient}. The next value is exposed so the top can register on the last step.
module alu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_kill,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic              o_last,
    output logic [2*XLEN-1:0] o_acc_nxt
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic              r_div;

    logic [XLEN:0]     w_madd;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [XLEN:0]     w_rsh;
    logic [XLEN+1:0]   w_diff;
    logic [2*XLEN-1:0] w_div_nxt;

    // Multiply: add multiplicand into the high half when the LSB is set, then shift right.
    assign w_madd    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_madd, r_acc[XLEN-1:1]};

    // Divide: shift next dividend bit into the remainder, subtract if it fits.
    assign w_rsh     = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = {1'b0, w_rsh} - {2'b00, r_b};
    assign w_div_nxt = w_diff[XLEN+1] ? {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                      : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign o_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;
    assign o_last    = i_step && (r_cnt == CW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || i_kill) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_start) begin
            r_cnt <= '0;
            r_acc <= {{XLEN{1'b0}}, i_a};
            r_b   <= i_b;
            r_div <= i_is_div;
        end else if (i_step) begin
            r_acc <= o_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle RV32I ops, iterative RV32M, valid/ready in and out with a held result register.
// Build macro ALU_FAST_MUL_EN: multiplies complete in one cycle through a combinational multiplier.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state, w_state_nxt;
    logic              r_out_valid, r_zero, r_neg_q, r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_op;

    logic              w_accept, w_iter, w_last, w_sa, w_sb, w_a_neg, w_b_neg;
    logic              w_div0, w_ovf;
    logic [SHW-1:0]    w_sh;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_imm, w_fix, w_q, w_r;
    logic [2*XLEN-1:0] w_it, w_prod;

    assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state == S_ITER);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

    // Operand signedness per op; MUL low word is sign-agnostic so it shares the signed path.
    assign w_sa    = (alu_control == OP_MUL) || (alu_control == OP_MULH) || (alu_control == OP_MULHSU)
                  || (alu_control == OP_DIV) || (alu_control == OP_REM);
    assign w_sb    = (alu_control == OP_MUL) || (alu_control == OP_MULH)
                  || (alu_control == OP_DIV) || (alu_control == OP_REM);
    assign w_a_neg = w_sa && op_a[XLEN-1];
    assign w_b_neg = w_sb && op_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -op_a : op_a;
    assign w_b_mag = w_b_neg ? -op_b : op_b;
    assign w_sh    = op_b[SHW-1:0];

    assign w_div0  = is_div(alu_control) && (op_b == '0);
    assign w_ovf   = ((alu_control == OP_DIV) || (alu_control == OP_REM))
                  && (op_a == INT_MIN) && (op_b == '1);

`ifdef ALU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fp;
    assign w_fa   = {{XLEN{w_a_neg}}, op_a};
    assign w_fb   = {{XLEN{w_b_neg}}, op_b};
    assign w_fp   = w_fa * w_fb;
    assign w_iter = is_div(alu_control) && !(w_div0 || w_ovf);
`else
    assign w_iter = is_muldiv(alu_control) && !(w_div0 || w_ovf);
`endif

    always_comb begin
        w_imm = op_a + op_b;
        unique case (alu_control)
            OP_SUB:  w_imm = op_a - op_b;
            OP_AND:  w_imm = op_a & op_b;
            OP_OR:   w_imm = op_a | op_b;
            OP_XOR:  w_imm = op_a ^ op_b;
            OP_SLT:  w_imm = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: w_imm = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_SLL:  w_imm = op_a << w_sh;
            OP_SRL:  w_imm = op_a >> w_sh;
            OP_SRA:  w_imm = $signed(op_a) >>> w_sh;
`ifdef ALU_FAST_MUL_EN
            OP_MUL:  w_imm = w_fp[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_imm = w_fp[2*XLEN-1:XLEN];
`endif
            OP_DIV, OP_DIVU: w_imm = w_div0 ? '1 : op_a;
            OP_REM, OP_REMU: w_imm = w_div0 ? op_a : '0;
            default: w_imm = op_a + op_b;
        endcase
    end

    alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_kill    (flush),
        .i_start   (w_accept && w_iter),
        .i_step    (r_state == S_ITER),
        .i_is_div  (is_div(alu_control)),
        .i_a       (w_a_mag),
        .i_b       (w_b_mag),
        .o_last    (w_last),
        .o_acc_nxt (w_it)
    );

    // Sign fixup on the final step: product/quotient by sign xor, remainder by dividend sign.
    assign w_prod = r_neg_q ? -w_it : w_it;
    assign w_q    = r_neg_q ? -w_it[XLEN-1:0] : w_it[XLEN-1:0];
    assign w_r    = r_neg_r ? -w_it[2*XLEN-1:XLEN] : w_it[2*XLEN-1:XLEN];

    always_comb begin
        w_fix = w_prod[2*XLEN-1:XLEN];
        unique case (r_op)
            OP_MUL:  w_fix = w_prod[XLEN-1:0];
            OP_DIV:  w_fix = w_q;
            OP_DIVU: w_fix = w_it[XLEN-1:0];
            OP_REM:  w_fix = w_r;
            OP_REMU: w_fix = w_it[2*XLEN-1:XLEN];
            default: w_fix = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept && w_iter) w_state_nxt = S_ITER;
            S_ITER:  if (w_last)             w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_op        <= OP_ADD;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept && !w_iter) begin
                r_result    <= w_imm;
                r_zero      <= (w_imm == '0);
                r_out_valid <= 1'b1;
            end else if (w_last) begin
                r_result    <= w_fix;
                r_zero      <= (w_fix == '0);
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_op    <= alu_control;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed cases then random ops against an arithmetic reference model.
module tb_alu_multicycle;
    import alu_pkg::*;

`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [4:0]  alu_control;
    logic [31:0] op_a, op_b, result;

    int checks = 0, failures = 0, cyc = 0;
    bit rnd_rdy = 1'b0, lat_done = 1'b0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    alu_multicycle #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference model straight from the ISA rules, using 64-bit integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        case (op)
            OP_SUB:    r = a - b;
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_SLT:    r = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:   r = (ua < ub) ? 32'd1 : 32'd0;
            OP_SLL:    r = a << b[4:0];
            OP_SRL:    r = a >> b[4:0];
            OP_SRA:    r = $signed(a) >>> b[4:0];
            OP_MUL:    begin p = sa * sb; r = p[31:0];  end
            OP_MULH:   begin p = sa * sb; r = p[63:32]; end
            OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
            OP_DIV:    if (b == 0) r = 32'hFFFFFFFF;
                       else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                       else begin p = sa / sb; r = p[31:0]; end
            OP_DIVU:   if (b == 0) r = 32'hFFFFFFFF; else begin p = ua / ub; r = p[31:0]; end
            OP_REM:    if (b == 0) r = a;
                       else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                       else begin p = sa % sb; r = p[31:0]; end
            OP_REMU:   if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end
            default:   r = a + b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= OP_MUL && op <= OP_MULHU) return MUL_LAT;
        if (op >= OP_DIV && op <= OP_REMU) begin
            if (b == 0) return 0;
            if ((op == OP_DIV || op == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
            return 32;
        end
        return 0;
    endfunction

    function automatic logic [31:0] rop();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: latency on first appearance of a result, value when it is taken.
    always @(negedge clk) begin
        if (!rst_n) lat_done = 1'b0;
        else if (out_valid) begin
            if (sbq.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            else begin
                if (!lat_done) begin
                    chk("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
                    lat_done = 1'b1;
                end
                if (out_ready) begin
                    chk("result", result, sbq[0].res);
                    chk("zero", 32'(zero), 32'(sbq[0].res == 0));
                    void'(sbq.pop_front());
                    lat_done = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int lat, input bit push, output int waited);
        alu_control = op; op_a = a; op_b = b; in_valid = 1'b1;
        #1; waited = 0;
        while (!in_ready && waited < 400) begin @(negedge clk); waited++; end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; alu_control = 5'($urandom); op_a = $urandom; op_b = $urandom;
        if (push) sbq.push_back('{exp_r, lat, cyc});
    endtask

    task automatic iss(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int lat);
        int w;
        issue(op, a, b, exp_r, lat, 1'b1, w);
    endtask

    task automatic busy_chk(input bit exp_busy);
        @(negedge clk);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("in_ready_vs_busy", 32'(in_ready), 32'(!exp_busy));
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int w;
        logic [4:0]  op;
        logic [31:0] a, b;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_control = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        iss(OP_ADD, 32'd7, 32'd5, 32'd12, 0);
        iss(OP_SUB, 32'd5, 32'd5, 32'd0, 0);
        iss(OP_SRA, 32'hF0000000, 32'd4, 32'hFF000000, 0);

        iss(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32); busy_chk(1'b1);
        iss(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32); busy_chk(1'b1);
        iss(OP_DIVU, 32'd100, 32'd7, 32'd14, 32);           busy_chk(1'b1);

        iss(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 0);                 busy_chk(1'b0);
        iss(OP_REMU, 32'd5, 32'd0, 32'd5, 0);                       busy_chk(1'b0);
        iss(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);   busy_chk(1'b0);

        iss(OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        iss(OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT);
        iss(OP_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, MUL_LAT);

        // Held result: no accept until taken, then back-to-back replacement.
        drain();
        out_ready = 1'b0;
        iss(OP_ADD, 32'd3, 32'd4, 32'd7, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_result", result, 32'd7);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(OP_XOR, 32'hFF, 32'h0F, 32'hF0, 0, 1'b1, w);
        chk("b2b_wait", 32'(w), 32'd0);

        // Flush mid-divide.
        drain();
        issue(OP_DIVU, 32'd1000, 32'd7, 32'd0, 32, 1'b0, w);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (35) @(negedge clk);
        chk("flush_no_result", 32'(out_valid), 32'd0);
        iss(OP_ADD, 32'd1, 32'd2, 32'd3, 0);

        // Flush beats a simultaneous accept.
        drain();
        @(posedge clk); #1;
        alu_control = OP_ADD; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_wins", 32'(out_valid), 32'd0);

        // Reset mid-iteration.
        issue(OP_DIV, 32'd77, 32'd3, 32'd0, 32, 1'b0, w);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        iss(OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 0);

        // Random traffic with random consumer backpressure.
        drain();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(10, 17)) : 5'($urandom_range(0, 31));
            a = rop(); b = rop();
            iss(op, a, b, ref_alu(op, a, b), ref_lat(op, a, b));
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
